ram_responder: RTL and testbench

Memory-side responder for the single-read-port/single-write-port RAM protocol (raddr_0/rdata_0, waddr_0/wen_0/wdata_0) that our datapath kernels drive as initiators. It holds the backing array and answers port reads with a registered 1-cycle-latency response. It commits port writes, and provides bench-facing debug read/write ports. After reset it runs an optional hardware clear sequence and flags out-of-range accesses.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_clear_seq.sv | 54 +++++
 rtl/ram_responder.sv | 98 +++++++++
 tb/tb_ram_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAM responder: FSM state encoding,
// default geometry and the address range check.
package ram_pkg;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_RUN   = 1'b1
  } ram_state_e;

  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Callers zero-extend their address to 64 bits so one helper serves any ADDR_W.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every index writing zero, then parks in RUN.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned IDX_W          = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr,
  output logic             init_done
);

  localparam ram_state_e RST_STATE = CLEAR_ON_RESET ? RAM_CLEAR : RAM_RUN;

  ram_state_e       r_state;
  ram_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RST_STATE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    clr_we      = 1'b0;
    case (r_state)
      RAM_CLEAR: begin
        clr_we    = 1'b1;
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = RAM_RUN;
          w_idx_nxt   = '0;
        end
      end
      RAM_RUN: ;
      default: w_state_nxt = RST_STATE;
    endcase
  end

  assign clr_addr  = r_idx;
  assign init_done = (r_state == RAM_RUN);

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: backing array, port/debug write arbitration,
// registered 1-cycle read port and sticky out-of-range flag.
module ram_responder
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic [ADDR_W-1:0] waddr_0,
  input  logic              wen_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic [DATA_W-1:0] debug_data,
  input  logic [ADDR_W-1:0] debug_write_addr,
  input  logic [DATA_W-1:0] debug_write_data,
  input  logic              debug_write_en,
  output logic              init_done,
  output logic              err_oob
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_addr;
  logic              w_run;
  logic              w_rd_ok, w_wr_ok, w_dw_ok, w_dbg_ok;
  logic              w_pw, w_dw, w_oob;
  logic [DATA_W-1:0] w_rd_val;

  ram_clear_seq #(
    .DEPTH          (DEPTH),
    .IDX_W          (IDX_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .init_done (w_run)
  );

  assign w_rd_ok  = in_range(64'(raddr_0), DEPTH);
  assign w_wr_ok  = in_range(64'(waddr_0), DEPTH);
  assign w_dw_ok  = in_range(64'(debug_write_addr), DEPTH);
  assign w_dbg_ok = in_range(64'(debug_addr), DEPTH);
  assign w_pw     = w_run && wen_0 && w_wr_ok;
  assign w_dw     = w_run && debug_write_en && w_dw_ok;
  assign w_oob    = w_run && (!w_rd_ok || (wen_0 && !w_wr_ok) || (debug_write_en && !w_dw_ok));

  // Write-first bypass mirrors the array's write priority: debug over port.
  always_comb begin
    w_rd_val = '0;
    if (w_rd_ok) begin
      w_rd_val = r_mem[raddr_0[IDX_W-1:0]];
      if (w_pw && (waddr_0 == raddr_0))
        w_rd_val = wdata_0;
      if (w_dw && (debug_write_addr == raddr_0))
        w_rd_val = debug_write_data;
    end
  end

  // Array is never reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_clr_we) begin
        r_mem[w_clr_addr] <= '0;
      end else begin
        if (w_pw) r_mem[waddr_0[IDX_W-1:0]] <= wdata_0;
        if (w_dw) r_mem[debug_write_addr[IDX_W-1:0]] <= debug_write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= w_run ? w_rd_val : '0;
      if (w_oob) r_err <= 1'b1;
    end
  end

  assign rdata_0    = r_rdata;
  assign err_oob    = r_err;
  assign init_done  = w_run;
  assign debug_data = w_dbg_ok ? r_mem[debug_addr[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder with a read-response scoreboard and a word model.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr_0, waddr_0, wdata_0;
  logic        wen_0;
  logic [31:0] rdata_0;
  logic [31:0] debug_addr, debug_data;
  logic [31:0] debug_write_addr, debug_write_data;
  logic        debug_write_en;
  logic        init_done, err_oob;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [16];
  logic [31:0] sb_q [$];
  string       sb_tag [$];

  always #5 clk = ~clk;

  ram_responder #(
    .DEPTH          (16),
    .ADDR_W         (32),
    .DATA_W         (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .raddr_0          (raddr_0),
    .rdata_0          (rdata_0),
    .waddr_0          (waddr_0),
    .wen_0            (wen_0),
    .wdata_0          (wdata_0),
    .debug_addr       (debug_addr),
    .debug_data       (debug_data),
    .debug_write_addr (debug_write_addr),
    .debug_write_data (debug_write_data),
    .debug_write_en   (debug_write_en),
    .init_done        (init_done),
    .err_oob          (err_oob)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] v);
    sb_q.push_back(v);
    sb_tag.push_back(tag);
  endtask

  task automatic tick_chk();
    string       t;
    logic [31:0] v;
    tick();
    while (sb_q.size() > 0) begin
      t = sb_tag.pop_front();
      v = sb_q.pop_front();
      check(t, rdata_0, v);
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [31:0] a);
    debug_addr = a;
    #1;
    check(tag, debug_data, (a < 32'd16) ? model[a[3:0]] : 32'd0);
  endtask

  task automatic dbg_wr(input logic [31:0] a, input logic [31:0] d);
    debug_write_addr = a;
    debug_write_data = d;
    debug_write_en   = 1'b1;
    tick();
    debug_write_en   = 1'b0;
    if (a < 32'd16) model[a[3:0]] = d;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
  endtask

  task automatic wait_init(input string tag, input int exp_edges);
    int cnt = 0;
    while (!init_done && cnt < 64) begin
      tick();
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_edges));
  endtask

  // Read-add-2 initiator: reads word 10, writes word 12 with the value plus two.
  task automatic run_initiator();
    logic [31:0] v;
    raddr_0 = 32'd10;
    tick();
    v = rdata_0;
    waddr_0 = 32'd12;
    wdata_0 = v + 32'd2;
    wen_0   = 1'b1;
    tick();
    wen_0   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    raddr_0 = '0; waddr_0 = '0; wdata_0 = '0; wen_0 = 1'b0;
    debug_addr = '0; debug_write_addr = '0; debug_write_data = '0; debug_write_en = 1'b0;
    zero_model();
    tick();
    tick();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rdata", rdata_0, 32'd0);
    check("rst_err", 32'(err_oob), 32'd0);

    rst = 1'b1;
    wait_init("clear_len_first", 16);
    dbg_chk("clear_word0", 32'd0);
    dbg_wr(32'd3, 32'd7);
    dbg_chk("preload_word3", 32'd3);

    rst = 1'b0;
    tick();
    check("rerst_init_done", 32'(init_done), 32'd0);
    rst = 1'b1;
    wait_init("clear_len_rerun", 16);
    zero_model();
    dbg_chk("cleared_word3", 32'd3);

    dbg_wr(32'd10, 32'd15);
    raddr_0 = 32'd10;
    expect_rd("rd_latency", 32'd15);
    tick_chk();
    wen_0 = 1'b1; waddr_0 = 32'd10; wdata_0 = 32'd17;
    expect_rd("write_first", 32'd17);
    tick_chk();
    wen_0 = 1'b0;
    model[10] = 32'd17;
    dbg_chk("write_first_dbg", 32'd10);

    wen_0 = 1'b1; waddr_0 = 32'd12; wdata_0 = 32'd5;
    debug_write_en = 1'b1; debug_write_addr = 32'd12; debug_write_data = 32'd9;
    raddr_0 = 32'd12;
    expect_rd("collide_rd", 32'd9);
    tick_chk();
    wen_0 = 1'b0; debug_write_en = 1'b0;
    model[12] = 32'd9;
    dbg_chk("collide_dbg", 32'd12);

    wen_0 = 1'b1; waddr_0 = 32'd4; wdata_0 = 32'd1;
    debug_write_en = 1'b1; debug_write_addr = 32'd5; debug_write_data = 32'd2;
    tick();
    wen_0 = 1'b0; debug_write_en = 1'b0;
    model[4] = 32'd1; model[5] = 32'd2;
    dbg_chk("split_port", 32'd4);
    dbg_chk("split_dbg", 32'd5);
    check("err_before_oob", 32'(err_oob), 32'd0);

    raddr_0 = 32'd16;
    expect_rd("oob_rd", 32'd0);
    tick_chk();
    check("oob_rd_err", 32'(err_oob), 32'd1);
    raddr_0 = 32'd0;
    wen_0 = 1'b1; waddr_0 = 32'd20; wdata_0 = 32'hDEAD;
    debug_write_en = 1'b1; debug_write_addr = 32'd20; debug_write_data = 32'hBEEF;
    tick();
    wen_0 = 1'b0; debug_write_en = 1'b0;
    for (int i = 0; i < 16; i++) dbg_chk($sformatf("oob_wr_word%0d", i), 32'(i));
    dbg_chk("oob_dbg_read", 32'd16);
    repeat (5) tick();
    check("err_sticky", 32'(err_oob), 32'd1);

    rst = 1'b0;
    #1;
    check("rst_clears_err", 32'(err_oob), 32'd0);
    rst = 1'b1;
    repeat (8) tick();
    check("mid_clear_busy", 32'(init_done), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    wait_init("clear_len_restart", 16);
    zero_model();

    dbg_wr(32'd10, 32'd15);
    check("init_before_start", 32'(init_done), 32'd1);
    run_initiator();
    model[12] = 32'd17;
    dbg_chk("initiator_result", 32'd12);
    check("initiator_err", 32'(err_oob), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
